antialias_scheduler: RTL and testbench
======================================

Name: antialias_scheduler

Overview:
- Address/control sequencer for the antialias stage; replaces the 288-entry aliasing lookup ROM with counter-generated schedule.
- After a granule (576 samples, both channels) is loaded into the granule buffer, walks 288 read pairs (x,y), issuing dual-port read addresses, butterfly coefficient index and per-channel alias enables.
- Carries those tags through a pipeline matched to buffer read latency; output is stallable by the downstream hybrid-filterbank loader.

Parameters:
RD_LAT, 2, granule-buffer read latency in advancing cycles (1..3)
N_SB, 32, subbands per granule (schedule sized for 32; other values unsupported)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
start  in  1  pulse: granule buffer loaded; latch side info, begin schedule
window_switching_flag_in  in  2  per channel [0]=ch1, [1]=ch2
block_type_in  in  2x2  per channel
mixed_block_flag_in  in  2  per channel
rd_addr_x  out  10  port A read address
rd_addr_y  out  10  port B read address
rd_en  out  1  buffer port enable/regce; high = pipeline advances
c_idx_out  out  3  coefficient index aligned with read data
alias_en_out  out  2  per-channel "apply butterfly" aligned with read data
is_pos_out_x  out  10  sample index of x data
is_pos_out_y  out  10  sample index of y data
out_v  out  1  aligned tags + buffer data valid
out_rdy  in  1  downstream accepts when out_v && out_rdy
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when last pair accepted

Behaviour:
- Reset (rst low, async): state IDLE, counters 0, out_v 0, done 0, busy 0, rd_en 0, all address/tag outputs 0, tag pipeline valid bits 0.
- States: IDLE -> RUN on start; RUN -> DRAIN after 288th pair issued; DRAIN -> IDLE when last pair accepted (done pulses that cycle). start ignored when not IDLE.
- Side info latched on accepted start; later input changes ignored until next start.
- Schedule counters: s (0..31), k (0..8); pair index p = 9s+k; k wraps 8->0 with s++. Issue order p=0..287.
  - s<=30, k<=7: x=18s+17-k, y=18s+18+k, alias=1, c_idx=k.
  - s<=31, k=8: x=18s+8, y=18s+9, alias=0, c_idx=0.
  - s=31, k<=7: x=k, y=568+k, alias=0, c_idx=0.
  - Every index 0..575 appears exactly once over the 288 pairs.
- Per-channel enable c: short_only = wsf[c] && bt[c]==2 && !mbf[c]; mixed = wsf[c] && bt[c]==2 && mbf[c]; alias_en[c] = alias && !short_only && (!mixed || s==0).
- Advance = !out_v || out_rdy; rd_en = advance && (state!=IDLE). Counters step and tag pipeline (RD_LAT stages) shift only when rd_en high; buffer holds output when rd_en low, so data and tags stay aligned.
- Issue slot valid = state==RUN; out_v = valid bit at pipeline tail. First out_v RD_LAT advancing cycles after first issue (2 cycles with out_rdy held high).
- out_v stable with tags unchanged while out_rdy low.
- Exactly 288 out_v&&out_rdy handshakes per start; done asserted in the cycle of the 288th handshake; busy drops next cycle.
- rst asserted mid-operation: immediate return to reset values; partial schedule discarded, no done.

Test Plan:
- Long blocks both ch (wsf=0), out_rdy=1, start pulse -> out_v first 2 cycles later; 288 consecutive valids; first pair x=17,y=18,c_idx=0,alias_en=2'b11; pair 8 x=8,y=9,alias_en=00; done on 288th; 248 pairs alias_en=11.
- ch1 short non-mixed (wsf=1,bt=2,mbf=0), ch2 long -> alias_en[0]=0 for all pairs; alias_en[1] pattern as above.
- ch1 mixed (wsf=1,bt=2,mbf=1) -> alias_en[0]=1 only for pairs 0..7 (x=17..10, y=18..25); 0 elsewhere.
- Random out_rdy 50% -> tags never change while out_v&&!out_rdy; scoreboard confirms union of is_pos_x/y = {0..575}, no duplicates, 288 handshakes, single done.
- start asserted during RUN and again in done cycle -> both ignored; next start in IDLE launches fresh schedule from p=0.
- rst low at pair 100 -> outputs zero asynchronously; after release, start gives full 288-pair schedule starting x=17,y=18.

Source files
------------

// File: rtl/antialias_scheduler.sv
// rtl/antialias_scheduler.sv - counter-generated antialias read schedule with latency-matched tag pipeline
// Walks 288 (x,y) butterfly pairs per granule and carries their tags alongside buffer read data.
module antialias_scheduler #(
  parameter int RD_LAT = 2,
  parameter int N_SB   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      window_switching_flag_in,
  input  logic [1:0][1:0] block_type_in,
  input  logic [1:0]      mixed_block_flag_in,
  output logic [9:0]      rd_addr_x,
  output logic [9:0]      rd_addr_y,
  output logic            rd_en,
  output logic [2:0]      c_idx_out,
  output logic [1:0]      alias_en_out,
  output logic [9:0]      is_pos_out_x,
  output logic [9:0]      is_pos_out_y,
  output logic            out_v,
  input  logic            out_rdy,
  output logic            busy,
  output logic            done
);

  localparam logic [4:0] S_LAST = 5'(N_SB - 1);
  localparam logic [9:0] TAIL_Y = 10'(18 * N_SB - 8);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic       last;
    logic [1:0] alias_en;
    logic [2:0] c_idx;
    logic [9:0] x;
    logic [9:0] y;
  } tag_t;

  state_t            state_q, state_d;
  logic [4:0]        s_q, s_d;
  logic [3:0]        k_q, k_d;
  logic [1:0]        wsf_q, wsf_d;
  logic [1:0][1:0]   bt_q, bt_d;
  logic [1:0]        mbf_q, mbf_d;
  tag_t              pipe_q [RD_LAT];
  tag_t              pipe_d [RD_LAT];
  logic [RD_LAT-1:0] vld_q, vld_d;

  tag_t       iss;
  logic       iss_alias;
  logic [9:0] s18;
  logic [9:0] k10;
  logic [1:0] short_only;
  logic [1:0] mixed;
  logic       advance;

  // Pair geometry for the current (s,k) slot.
  always_comb begin
    s18        = {5'd0, s_q} * 10'd18;
    k10        = {6'd0, k_q};
    iss        = '0;
    iss_alias  = 1'b0;
    short_only = '0;
    mixed      = '0;
    if (k_q == 4'd8) begin
      iss.x = s18 + 10'd8;
      iss.y = s18 + 10'd9;
    end else if (s_q == S_LAST) begin
      iss.x = k10;
      iss.y = TAIL_Y + k10;
    end else begin
      iss.x     = s18 + 10'd17 - k10;
      iss.y     = s18 + 10'd18 + k10;
      iss.c_idx = k_q[2:0];
      iss_alias = 1'b1;
    end
    for (int c = 0; c < 2; c++) begin
      short_only[c]   = wsf_q[c] && (bt_q[c] == 2'd2) && !mbf_q[c];
      mixed[c]        = wsf_q[c] && (bt_q[c] == 2'd2) && mbf_q[c];
      iss.alias_en[c] = iss_alias && !short_only[c] && (!mixed[c] || (s_q == 5'd0));
    end
    iss.last = (s_q == S_LAST) && (k_q == 4'd8);
  end

  assign out_v        = vld_q[RD_LAT-1];
  assign c_idx_out    = pipe_q[RD_LAT-1].c_idx;
  assign alias_en_out = pipe_q[RD_LAT-1].alias_en;
  assign is_pos_out_x = pipe_q[RD_LAT-1].x;
  assign is_pos_out_y = pipe_q[RD_LAT-1].y;
  assign advance      = !out_v || out_rdy;
  assign rd_en        = advance && (state_q != IDLE);
  assign busy         = (state_q != IDLE);
  assign done         = out_v && out_rdy && pipe_q[RD_LAT-1].last;
  assign rd_addr_x    = (state_q == RUN) ? iss.x : 10'd0;
  assign rd_addr_y    = (state_q == RUN) ? iss.y : 10'd0;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    wsf_d   = wsf_q;
    bt_d    = bt_q;
    mbf_d   = mbf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          s_d     = 5'd0;
          k_d     = 4'd0;
          wsf_d   = window_switching_flag_in;
          bt_d    = block_type_in;
          mbf_d   = mixed_block_flag_in;
        end
      end
      RUN: begin
        if (rd_en) begin
          if (iss.last) state_d = DRAIN;
          if (k_q == 4'd8) begin
            k_d = 4'd0;
            s_d = s_q + 5'd1;
          end else begin
            k_d = k_q + 4'd1;
          end
        end
      end
      DRAIN: begin
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Tags shift only with the buffer's regce so they stay aligned with read data.
  always_comb begin
    vld_d = vld_q;
    for (int i = 0; i < RD_LAT; i++) pipe_d[i] = pipe_q[i];
    if (rd_en) begin
      vld_d[0]  = (state_q == RUN);
      pipe_d[0] = (state_q == RUN) ? iss : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_d[i]  = vld_q[i-1];
        pipe_d[i] = pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      k_q     <= '0;
      wsf_q   <= '0;
      bt_q    <= '0;
      mbf_q   <= '0;
      vld_q   <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      wsf_q   <= wsf_d;
      bt_q    <= bt_d;
      mbf_q   <= mbf_d;
      vld_q   <= vld_d;
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= pipe_d[i];
    end
  end

endmodule

// File: tb/tb_antialias_scheduler.sv
// tb/tb_antialias_scheduler.sv - scoreboard bench for antialias_scheduler
module tb_antialias_scheduler;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [1:0]      wsf_in;
  logic [1:0][1:0] bt_in;
  logic [1:0]      mbf_in;
  logic [9:0]      rd_addr_x, rd_addr_y;
  logic            rd_en;
  logic [2:0]      c_idx_out;
  logic [1:0]      alias_en_out;
  logic [9:0]      is_pos_out_x, is_pos_out_y;
  logic            out_v;
  logic            out_rdy;
  logic            busy;
  logic            done;

  always #5 clk = ~clk;

  antialias_scheduler #(.RD_LAT(2), .N_SB(32)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .start                    (start),
    .window_switching_flag_in (wsf_in),
    .block_type_in            (bt_in),
    .mixed_block_flag_in      (mbf_in),
    .rd_addr_x                (rd_addr_x),
    .rd_addr_y                (rd_addr_y),
    .rd_en                    (rd_en),
    .c_idx_out                (c_idx_out),
    .alias_en_out             (alias_en_out),
    .is_pos_out_x             (is_pos_out_x),
    .is_pos_out_y             (is_pos_out_y),
    .out_v                    (out_v),
    .out_rdy                  (out_rdy),
    .busy                     (busy),
    .done                     (done)
  );

  typedef struct packed {
    logic       last;
    logic [1:0] al;
    logic [2:0] c;
    logic [9:0] x;
    logic [9:0] y;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  int         hs_cnt, done_cnt, al11_cnt, al0_cnt, al1_cnt;
  int         cov[576];
  logic [9:0] first_x, first_y, p8_x, p8_y;
  logic [1:0] first_al, p8_al;
  bit         rnd_rdy = 1'b0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Output ready: held high, or random 50% when requested.
  initial begin
    out_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every handshake; checks stall stability.
  initial begin
    bit          prev_stall;
    logic [25:0] prev_tag, cur;
    exp_t        e;
    prev_stall = 1'b0;
    prev_tag   = '0;
    forever begin
      @(negedge clk);
      cur = {out_v, is_pos_out_x, is_pos_out_y, c_idx_out, alias_en_out};
      if (rst) begin
        if (prev_stall) check("stall_hold", int'(cur), int'(prev_tag));
        if (out_v && out_rdy) begin
          if (sb.size() == 0) begin
            check("unexpected_out", int'(is_pos_out_x), -1);
          end else begin
            e = sb.pop_front();
            check("pair_x", int'(is_pos_out_x), int'(e.x));
            check("pair_y", int'(is_pos_out_y), int'(e.y));
            check("pair_c", int'(c_idx_out), int'(e.c));
            check("pair_alias", int'(alias_en_out), int'(e.al));
            check("done_align", int'(done), int'(e.last));
          end
          if (hs_cnt == 0) begin
            first_x = is_pos_out_x; first_y = is_pos_out_y; first_al = alias_en_out;
          end
          if (hs_cnt == 8) begin
            p8_x = is_pos_out_x; p8_y = is_pos_out_y; p8_al = alias_en_out;
          end
          if (is_pos_out_x < 10'd576) cov[is_pos_out_x]++;
          if (is_pos_out_y < 10'd576) cov[is_pos_out_y]++;
          if (alias_en_out == 2'b11) al11_cnt++;
          if (alias_en_out[0]) al0_cnt++;
          if (alias_en_out[1]) al1_cnt++;
          hs_cnt++;
        end else begin
          check("done_without_hs", int'(done), 0);
        end
        if (done) done_cnt++;
        prev_stall = out_v && !out_rdy;
        prev_tag   = cur;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic clear_stats();
    hs_cnt = 0; done_cnt = 0; al11_cnt = 0; al0_cnt = 0; al1_cnt = 0;
    for (int i = 0; i < 576; i++) cov[i] = 0;
  endtask

  task automatic load_exp(input logic [1:0] wsf, input logic [1:0][1:0] bt, input logic [1:0] mbf);
    for (int p = 0; p < 288; p++) begin
      int   s, k, x, y, c;
      bit   al, sh, mx;
      exp_t e;
      s = p / 9;
      k = p % 9;
      if (k == 8) begin
        x = 18 * s + 8; y = 18 * s + 9; c = 0; al = 0;
      end else if (s == 31) begin
        x = k; y = 568 + k; c = 0; al = 0;
      end else begin
        x = 18 * s + 17 - k; y = 18 * s + 18 + k; c = k; al = 1;
      end
      e.x = 10'(x);
      e.y = 10'(y);
      e.c = 3'(c);
      for (int ch = 0; ch < 2; ch++) begin
        sh = wsf[ch] && (bt[ch] == 2'd2) && !mbf[ch];
        mx = wsf[ch] && (bt[ch] == 2'd2) && mbf[ch];
        e.al[ch] = al && !sh && (!mx || s == 0);
      end
      e.last = (p == 287);
      sb.push_back(e);
    end
  endtask

  task automatic pulse_start(input logic [1:0] wsf, input logic [1:0][1:0] bt, input logic [1:0] mbf);
    @(posedge clk);
    #1;
    wsf_in = wsf; bt_in = bt; mbf_in = mbf; start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    wsf_in = ~wsf; bt_in = ~bt; mbf_in = ~mbf;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("timeout", int'(done_cnt > 0), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic end_checks();
    int misses;
    misses = 0;
    for (int i = 0; i < 576; i++) if (cov[i] != 1) misses++;
    check("handshakes", hs_cnt, 288);
    check("done_count", done_cnt, 1);
    check("sb_empty", sb.size(), 0);
    check("coverage_misses", misses, 0);
    check("busy_after", int'(busy), 0);
  endtask

  initial begin
    int n;
    rst = 1'b0; start = 1'b0; wsf_in = '0; bt_in = '0; mbf_in = '0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_v", int'(out_v), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_rd_en", int'(rd_en), 0);
    check("rst_addr_x", int'(rd_addr_x), 0);
    check("rst_tag_x", int'(is_pos_out_x), 0);
    rst = 1'b1;

    // Long blocks, out_rdy high, latency check.
    clear_stats();
    load_exp(2'b00, '0, 2'b00);
    @(posedge clk);
    #1;
    wsf_in = 2'b00; bt_in = '0; mbf_in = 2'b00; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; wsf_in = 2'b11; bt_in = {2'd2, 2'd2};
    check("busy_on_start", int'(busy), 1);
    @(posedge clk);
    #1;
    check("lat_one_cycle", int'(out_v), 0);
    @(posedge clk);
    #1;
    check("lat_two_cycles", int'(out_v), 1);
    wait_done(2000);
    end_checks();
    check("first_x", int'(first_x), 17);
    check("first_y", int'(first_y), 18);
    check("first_alias", int'(first_al), 3);
    check("p8_x", int'(p8_x), 8);
    check("p8_y", int'(p8_y), 9);
    check("p8_alias", int'(p8_al), 0);
    check("alias11_count", al11_cnt, 248);

    // ch1 short non-mixed, ch2 long.
    clear_stats();
    load_exp(2'b01, {2'd0, 2'd2}, 2'b00);
    pulse_start(2'b01, {2'd0, 2'd2}, 2'b00);
    wait_done(2000);
    end_checks();
    check("short_al0", al0_cnt, 0);
    check("short_al1", al1_cnt, 248);

    // ch1 mixed.
    clear_stats();
    load_exp(2'b01, {2'd0, 2'd2}, 2'b01);
    pulse_start(2'b01, {2'd0, 2'd2}, 2'b01);
    wait_done(2000);
    end_checks();
    check("mixed_al0", al0_cnt, 8);
    check("mixed_al1", al1_cnt, 248);

    // Random backpressure.
    clear_stats();
    rnd_rdy = 1'b1;
    load_exp(2'b00, '0, 2'b00);
    pulse_start(2'b00, '0, 2'b00);
    wait_done(4000);
    rnd_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    end_checks();

    // start during RUN and in the done cycle must be ignored.
    clear_stats();
    load_exp(2'b10, {2'd2, 2'd0}, 2'b00);
    pulse_start(2'b10, {2'd2, 2'd0}, 2'b00);
    repeat (20) @(posedge clk);
    pulse_start(2'b11, {2'd2, 2'd2}, 2'b00);
    n = 0;
    while (hs_cnt < 287 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reach_287", hs_cnt, 287);
    @(posedge clk);
    #1;
    start = 1'b1;
    check("done_cycle", int'(done), 1);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_drop", int'(busy), 0);
    repeat (5) @(posedge clk);
    #1;
    check("ignored_out_v", int'(out_v), 0);
    check("ignored_busy", int'(busy), 0);
    end_checks();

    // Reset mid-schedule, then a fresh schedule.
    clear_stats();
    load_exp(2'b00, '0, 2'b00);
    pulse_start(2'b00, '0, 2'b00);
    n = 0;
    while (hs_cnt < 100 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reach_100", hs_cnt, 100);
    #2;
    rst = 1'b0;
    #1;
    check("arst_out_v", int'(out_v), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_rd_en", int'(rd_en), 0);
    check("arst_addr_x", int'(rd_addr_x), 0);
    check("arst_addr_y", int'(rd_addr_y), 0);
    check("arst_tag_x", int'(is_pos_out_x), 0);
    check("arst_alias", int'(alias_en_out), 0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("no_done_on_reset", done_cnt, 0);
    clear_stats();
    load_exp(2'b00, '0, 2'b00);
    pulse_start(2'b00, '0, 2'b00);
    wait_done(2000);
    end_checks();
    check("restart_first_x", int'(first_x), 17);
    check("restart_first_y", int'(first_y), 18);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
